// File: rtl/prog_check_sequencer_pkg.sv
// Shared types and helpers for the program-run sequencer/checker.
package prog_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRST,
    RUN,
    SETTLE,
    CHECK,
    NEXT,
    DONE
  } prog_check_state_t;

  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_check_sequencer_wdog.sv
// Saturating run-cycle watchdog; expired while the count sits at all-ones.
module wdog_counter #(
  parameter int WDOG_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] count;

  assign expired = (count == '1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/prog_check_sequencer.sv
// Sequences reset/run/settle/compare over a table of programs for the
// single-cycle processor and accumulates pass/timeout results.
module prog_check_sequencer
  import prog_check_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int PC_W          = 64,
  parameter int NUM_PROGS     = 4,
  parameter int WDOG_W        = 16,
  parameter int RESET_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          start,
  input  logic [NUM_PROGS*PC_W-1:0]     progStartPC,
  input  logic [NUM_PROGS*PC_W-1:0]     progEndPC,
  input  logic [NUM_PROGS*DATA_W-1:0]   progExpected,
  input  logic [PC_W-1:0]               currentPC,
  input  logic [DATA_W-1:0]             dMemOut,
  output logic                          procReset_L,
  output logic [PC_W-1:0]               startPC,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W(NUM_PROGS)-1:0]   progIdx,
  output logic [NUM_PROGS-1:0]          passMask,
  output logic [NUM_PROGS-1:0]          timeoutMask,
  output logic [7:0]                    passCount,
  output logic                          allPassed,
  output logic [DATA_W-1:0]             failData
);

  localparam int IW = IDX_W(NUM_PROGS);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_PROGS - 1);
  localparam logic [15:0]   RST_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0]   SET_LAST   = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  prog_check_state_t state, state_n;
  logic [IW-1:0]      idx_n;
  logic [15:0]        phase;
  logic               clear_res, pass_hit, fail_hit, tmo_hit;
  logic               wdog_expired;
  logic [PC_W-1:0]    cur_end, next_start;
  logic [DATA_W-1:0]  cur_exp;
  logic [NUM_PROGS-1:0] idx_bit;

  wdog_counter #(.WDOG_W(WDOG_W)) u_wdog (
    .clk     (CLK),
    .reset   (Reset),
    .clr     (state == PRST),
    .en      (state == RUN),
    .expired (wdog_expired)
  );

  // Slot selection: the end/expected values follow the current slot, while
  // startPC is loaded for the slot being entered so it is valid throughout PRST.
  always_comb begin
    cur_end    = '0;
    cur_exp    = '0;
    next_start = '0;
    for (int unsigned i = 0; i < NUM_PROGS; i++) begin
      if (progIdx == IW'(i)) begin
        cur_end = progEndPC[i*PC_W +: PC_W];
        cur_exp = progExpected[i*DATA_W +: DATA_W];
      end
      if (idx_n == IW'(i)) begin
        next_start = progStartPC[i*PC_W +: PC_W];
      end
    end
  end

  assign idx_bit = NUM_PROGS'(1) << progIdx;

  always_comb begin
    state_n   = state;
    idx_n     = progIdx;
    clear_res = 1'b0;
    pass_hit  = 1'b0;
    fail_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = PRST;
          idx_n     = '0;
          clear_res = 1'b1;
        end
      end
      PRST:   if (phase == RST_LAST) state_n = RUN;
      RUN: begin
        if (currentPC >= cur_end) begin
          state_n = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
        end else if (wdog_expired) begin
          tmo_hit = 1'b1;
          state_n = NEXT;
        end
      end
      SETTLE: if (phase == SET_LAST) state_n = CHECK;
      CHECK: begin
        if (dMemOut == cur_exp) pass_hit = 1'b1;
        else                    fail_hit = 1'b1;
        state_n = NEXT;
      end
      NEXT: begin
        if (progIdx == LAST_IDX) begin
          state_n = DONE;
        end else begin
          idx_n   = progIdx + IW'(1);
          state_n = PRST;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      phase       <= '0;
      procReset_L <= 1'b0;
      startPC     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      progIdx     <= '0;
      passMask    <= '0;
      timeoutMask <= '0;
      passCount   <= '0;
      allPassed   <= 1'b0;
      failData    <= '0;
    end else begin
      state       <= state_n;
      progIdx     <= idx_n;
      phase       <= (state_n != state) ? 16'd0 : phase + 16'd1;
      procReset_L <= (state_n inside {RUN, SETTLE, CHECK});
      busy        <= (state_n inside {PRST, RUN, SETTLE, CHECK, NEXT});
      done        <= (state_n == DONE);
      allPassed   <= (state_n == DONE) && (passCount == 8'(NUM_PROGS));
      if (state_n == PRST) startPC <= next_start;
      if (clear_res) begin
        passMask    <= '0;
        timeoutMask <= '0;
        passCount   <= '0;
        failData    <= '0;
      end
      if (pass_hit) begin
        passMask  <= passMask | idx_bit;
        passCount <= passCount + 8'd1;
      end
      if (fail_hit) failData <= dMemOut;
      if (tmo_hit)  timeoutMask <= timeoutMask | idx_bit;
    end
  end

endmodule

// File: tb/tb_prog_check_sequencer.sv
// Directed bench for prog_check_sequencer: a timeline model predicts every
// output cycle by cycle, plus literal end-of-run expectations.
module tb_prog_check_sequencer;

  localparam int PW = 32;
  localparam int DW = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance 0: four slots, short watchdog, two settle cycles
  logic            reset0, start0;
  logic [4*PW-1:0] sp0, ep0;
  logic [4*DW-1:0] exv0;
  logic [PW-1:0]   pc0 = '0, spc0;
  logic [DW-1:0]   dm0 = '0, fd0;
  logic            rl0, busy0, done0, ap0;
  logic [1:0]      idx0;
  logic [3:0]      pm0, tm0;
  logic [7:0]      cnt0;

  // Instance 1: one slot, three reset cycles, no settle
  logic            reset1, start1;
  logic [PW-1:0]   sp1, ep1;
  logic [DW-1:0]   exv1;
  logic [PW-1:0]   pc1 = '0, spc1;
  logic [DW-1:0]   dm1 = '0, fd1;
  logic            rl1, busy1, done1, ap1;
  logic [0:0]      idx1;
  logic [0:0]      pm1, tm1;
  logic [7:0]      cnt1;

  prog_check_sequencer #(
    .DATA_W(DW), .PC_W(PW), .NUM_PROGS(4), .WDOG_W(4),
    .RESET_CYCLES(1), .SETTLE_CYCLES(2)
  ) u0 (
    .CLK(CLK), .Reset(reset0), .start(start0),
    .progStartPC(sp0), .progEndPC(ep0), .progExpected(exv0),
    .currentPC(pc0), .dMemOut(dm0),
    .procReset_L(rl0), .startPC(spc0), .busy(busy0), .done(done0),
    .progIdx(idx0), .passMask(pm0), .timeoutMask(tm0), .passCount(cnt0),
    .allPassed(ap0), .failData(fd0)
  );

  prog_check_sequencer #(
    .DATA_W(DW), .PC_W(PW), .NUM_PROGS(1), .WDOG_W(16),
    .RESET_CYCLES(3), .SETTLE_CYCLES(0)
  ) u1 (
    .CLK(CLK), .Reset(reset1), .start(start1),
    .progStartPC(sp1), .progEndPC(ep1), .progExpected(exv1),
    .currentPC(pc1), .dMemOut(dm1),
    .procReset_L(rl1), .startPC(spc1), .busy(busy1), .done(done1),
    .progIdx(idx1), .passMask(pm1), .timeoutMask(tm1), .passCount(cnt1),
    .allPassed(ap1), .failData(fd1)
  );

  // Program table: start PC, end PC, expected value, value the processor produces, PC stuck
  logic [31:0] st[4], en[4], ex[4], ac[4];
  bit          stk[4];

  function automatic bit stk_of(input logic [31:0] spc);
    for (int i = 0; i < 4; i++) if (st[i] == spc) return stk[i];
    return 1'b0;
  endfunction

  function automatic logic [31:0] ac_of(input logic [31:0] spc);
    for (int i = 0; i < 4; i++) if (st[i] == spc) return ac[i];
    return '0;
  endfunction

  // Processor stand-ins: PC loads startPC in reset, then steps by 4 unless stuck
  always @(posedge CLK) begin
    if (!rl0) pc0 <= spc0; else if (!stk_of(spc0)) pc0 <= pc0 + 32'd4;
    if (!rl1) pc1 <= spc1; else if (!stk_of(spc1)) pc1 <= pc1 + 32'd4;
    dm0 <= ac_of(spc0);
    dm1 <= ac_of(spc1);
  end

  task automatic load_tables();
    for (int i = 0; i < 4; i++) begin
      sp0[i*PW +: PW]  = st[i];
      ep0[i*PW +: PW]  = en[i];
      exv0[i*DW +: DW] = ex[i];
    end
    sp1  = st[0];
    ep1  = en[0];
    exv1 = ex[0];
  endtask

  typedef struct packed {
    logic        busy, done, rl;
    logic [1:0]  idx;
    logic [3:0]  pm, tm;
    logic [7:0]  pc;
    logic        ap;
    logic [31:0] fd, spc;
  } rec_t;

  rec_t act0, act1, cur0, cur1;
  rec_t q0[$], q1[$];
  bit   chk_en = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  always_comb act0 = '{busy: busy0, done: done0, rl: rl0, idx: idx0, pm: pm0, tm: tm0,
                       pc: cnt0, ap: ap0, fd: fd0, spc: spc0};
  always_comb act1 = '{busy: busy1, done: done1, rl: rl1, idx: {1'b0, idx1}, pm: {3'b0, pm1},
                       tm: {3'b0, tm1}, pc: cnt1, ap: ap1, fd: fd1, spc: spc1};

  task automatic chk_rec(input int u, input rec_t a, input rec_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL u%0d_trace t=%0t got busy=%b done=%b rl=%b idx=%0d pm=%b tm=%b cnt=%0d ap=%b fd=%h spc=%h | want busy=%b done=%b rl=%b idx=%0d pm=%b tm=%b cnt=%0d ap=%b fd=%h spc=%h",
               u, $time, a.busy, a.done, a.rl, a.idx, a.pm, a.tm, a.pc, a.ap, a.fd, a.spc,
               e.busy, e.done, e.rl, e.idx, e.pm, e.tm, e.pc, e.ap, e.fd, e.spc);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      if (q0.size() > 0) cur0 = q0.pop_front();
      chk_rec(0, act0, cur0);
      if (q1.size() > 0) cur1 = q1.pop_front();
      chk_rec(1, act1, cur1);
    end
  end

  // Leave only the record for the upcoming negedge queued and return it
  task automatic trim(input int u, output rec_t r);
    if (u == 0) begin
      if (q0.size() == 0) q0.push_back(cur0);
      while (q0.size() > 1) void'(q0.pop_back());
      r = q0[0];
    end else begin
      if (q1.size() == 0) q1.push_back(cur1);
      while (q1.size() > 1) void'(q1.pop_back());
      r = q1[0];
    end
  endtask

  task automatic push(input int u, input rec_t r);
    if (u == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  // Whole-run timeline: per slot, rc reset cycles, the run length implied by
  // the PC walk or the watchdog, sc settle cycles plus one compare, one step.
  task automatic build(input int u, input int n, input int rc, input int sc, input int w);
    rec_t   r;
    longint kend, tlim;
    bit     to;
    trim(u, r);
    r.pm = '0; r.tm = '0; r.pc = '0; r.fd = '0; r.ap = 1'b0; r.done = 1'b0;
    tlim = longint'(1) << w;
    for (int i = 0; i < n; i++) begin
      r.busy = 1'b1; r.idx = 2'(i); r.spc = st[i]; r.rl = 1'b0;
      repeat (rc) push(u, r);
      if (st[i] >= en[i])  kend = 1;
      else if (stk[i])     kend = tlim + 1;
      else                 kend = (longint'(en[i] - st[i]) + 3) / 4 + 1;
      to = (kend > tlim);
      r.rl = 1'b1;
      repeat (int'(to ? tlim : kend)) push(u, r);
      if (!to) begin
        repeat (sc) push(u, r);
        push(u, r);
        if (ac[i] == ex[i]) begin
          r.pm[i] = 1'b1;
          r.pc = r.pc + 8'd1;
        end else begin
          r.fd = ac[i];
        end
      end else begin
        r.tm[i] = 1'b1;
      end
      r.rl = 1'b0;
      push(u, r);
    end
    r.busy = 1'b0; r.done = 1'b1; r.ap = (r.pc == 8'(n));
    push(u, r);
  endtask

  task automatic do_reset(input int u);
    rec_t r;
    trim(u, r);
    push(u, '0);
  endtask

  task automatic pulse_start(input int u, input int n, input int rc, input int sc, input int w);
    if (u == 0) start0 = 1'b1; else start1 = 1'b1;
    build(u, n, rc, sc, w);
    @(posedge CLK); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int u, input string name);
    for (int c = 0; c < 2000; c++) begin
      if ((u == 0) ? done0 : done1) break;
      @(posedge CLK); #1;
    end
    chk(name, (u == 0) ? done0 : done1, 1);
  endtask

  task automatic set_tables_a();
    for (int i = 0; i < 4; i++) begin
      st[i]  = 32'h100 * i;
      en[i]  = st[i] + 32'h30;
      stk[i] = 1'b0;
    end
    ex[0] = 32'hF; ex[1] = 32'h1; ex[2] = 32'h2; ex[3] = 32'h3;
    ac[0] = 32'hF; ac[1] = 32'h1; ac[2] = 32'h7; ac[3] = 32'h3;
    load_tables();
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    set_tables_a();
    repeat (3) @(posedge CLK);
    #1;
    reset0 = 1'b0; reset1 = 1'b0;
    cur0 = '0; cur1 = '0;
    chk_en = 1'b1;
    chk("rst_busy", busy0, 0);
    chk("rst_procReset_L", rl0, 0);
    chk("rst_passMask", pm0, 0);
    chk("rst_passCount", cnt0, 0);
    repeat (2) @(posedge CLK);
    #1;

    // Four slots, slot 2 returns the wrong value
    pulse_start(0, 4, 1, 2, 4);
    wait_done(0, "runA_done");
    chk("runA_passMask", pm0, 4'b1011);
    chk("runA_passCount", cnt0, 3);
    chk("runA_failData", fd0, 32'h7);
    chk("runA_allPassed", ap0, 0);
    chk("runA_timeoutMask", tm0, 0);

    // Stuck PC, end PC coincident with expiry, and expiry one cycle short of end PC
    stk[0] = 1'b1; en[0] = 32'h30;
    en[1] = 32'h13C; en[2] = 32'h240; en[3] = 32'h330;
    ac[2] = 32'h2;
    load_tables();
    pulse_start(0, 4, 1, 2, 4);
    wait_done(0, "runB_done");
    chk("runB_timeoutMask", tm0, 4'b0101);
    chk("runB_passMask", pm0, 4'b1010);
    chk("runB_passCount", cnt0, 2);
    chk("runB_failData", fd0, 0);

    // Reset while slot 2 runs, then a clean restart
    set_tables_a();
    pulse_start(0, 4, 1, 2, 4);
    for (int c = 0; c < 300; c++) begin
      if (idx0 == 2'd2 && rl0) break;
      @(posedge CLK); #1;
    end
    chk("reach_slot2_run", {idx0, rl0}, {2'd2, 1'b1});
    reset0 = 1'b1;
    do_reset(0);
    @(posedge CLK); #1;
    reset0 = 1'b0;
    chk("midrst_busy", busy0, 0);
    chk("midrst_passMask", pm0, 0);
    chk("midrst_progIdx", idx0, 0);
    @(posedge CLK); #1;
    pulse_start(0, 4, 1, 2, 4);
    wait_done(0, "runC_done");
    chk("runC_passMask", pm0, 4'b1011);

    // start together with Reset: Reset wins
    reset0 = 1'b1; start0 = 1'b1;
    do_reset(0);
    @(posedge CLK); #1;
    reset0 = 1'b0; start0 = 1'b0;
    chk("rst_start_done", done0, 0);
    chk("rst_start_busy", busy0, 0);
    repeat (3) @(posedge CLK);
    #1;

    // Single slot, long reset, no settle; start mid-run is ignored
    st[0] = 32'h0; en[0] = 32'h30; ex[0] = 32'hF; ac[0] = 32'hF; stk[0] = 1'b0;
    load_tables();
    pulse_start(1, 1, 3, 0, 16);
    repeat (5) @(posedge CLK);
    #1;
    chk("u1_busy_midrun", busy1, 1);
    start1 = 1'b1;
    @(posedge CLK); #1;
    start1 = 1'b0;
    wait_done(1, "u1_done");
    chk("u1_passMask", pm1, 1);
    chk("u1_passCount", cnt1, 1);
    chk("u1_allPassed", ap1, 1);
    repeat (3) @(posedge CLK);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_check_sequencer.md
# prog_check_sequencer

Synthesizable program-run sequencer and checker for the single-cycle processor. It takes a table of NUM_PROGS programs, each with a start PC, an end PC and an expected `dMemOut` value. For each program in turn it resets the processor, runs it until `currentPC` reaches the end PC or a watchdog expires, waits for memory to settle, and compares the data-memory output. It sits beside `SingleCycleProc` on the test/bring-up path and replaces hand-sequenced reset/run/compare with a hardware pass mask and pass count.

## Interface
Parameters:
- `DATA_W`, 64: width of `dMemOut` and of expected values.
- `PC_W`, 64: PC width.
- `NUM_PROGS`, 4: number of program slots, ≥1.
- `WDOG_W`, 16: watchdog counter width; timeout at 2^WDOG_W−1 run cycles.
- `RESET_CYCLES`, 1: cycles `procReset_L` is held low per program, ≥1.
- `SETTLE_CYCLES`, 1: cycles waited after end PC before compare, ≥0.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock; all state changes on rising edge.
- `Reset`  in  1  synchronous active-high reset.
- `start`  in  1  pulse that begins a sequence; ignored while `busy`.
- `progStartPC`  in  NUM_PROGS*PC_W  packed start PCs; slot i is at [i*PC_W +: PC_W].
- `progEndPC`  in  NUM_PROGS*PC_W  packed end PCs.
- `progExpected`  in  NUM_PROGS*DATA_W  packed expected `dMemOut` values.
- `currentPC`  in  PC_W  processor PC.
- `dMemOut`  in  DATA_W  processor data-memory output.
- `procReset_L`  out  1  active-low reset to the processor.
- `startPC`  out  PC_W  start PC to the processor.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sequence finished; held until `start` or `Reset`.
- `progIdx`  out  $clog2(NUM_PROGS) (min 1)  current slot.
- `passMask`  out  NUM_PROGS  bit i set when slot i passed.
- `timeoutMask`  out  NUM_PROGS  bit i set when slot i hit the watchdog.
- `passCount`  out  8  number of passing slots.
- `allPassed`  out  1  `done` and `passCount == NUM_PROGS`.
- `failData`  out  DATA_W  `dMemOut` sampled at the most recent failing compare.

## Operation
- FSM states are IDLE, PRST, RUN, SETTLE, CHECK, NEXT and DONE.
- **IDLE**: `procReset_L` = 0. On `start`, clear `passMask`, `timeoutMask`, `passCount` and `failData`, set `progIdx` = 0, then go to PRST.
- **PRST**: `procReset_L` = 0 and `startPC` = progStartPC[progIdx] for RESET_CYCLES cycles. The watchdog clears. Then go to RUN.
- **RUN**: `procReset_L` = 1 and the watchdog increments each cycle.
  - If `currentPC` ≥ progEndPC[progIdx] (unsigned compare), go to SETTLE.
  - Otherwise, if the watchdog equals all-ones, set timeoutMask[idx] and go to NEXT.
  - End PC takes priority over timeout when both happen in the same cycle.
- **SETTLE**: count SETTLE_CYCLES cycles, then go to CHECK. With SETTLE_CYCLES = 0, go straight from RUN to CHECK.
- **CHECK**: one cycle.
  - If `dMemOut` == progExpected[idx], set passMask[idx] and increment `passCount`.
  - Otherwise capture `failData`.
  - Then go to NEXT.
- **NEXT**: if idx == NUM_PROGS−1, go to DONE; otherwise increment idx and go to PRST.
- **DONE**: `done` = 1 and `procReset_L` = 0. On `start`, behave as in IDLE.
- `procReset_L` is 1 only in RUN, SETTLE and CHECK.
- `busy` = 1 in PRST, RUN, SETTLE, CHECK and NEXT.
- `Reset` mid-sequence returns the FSM to IDLE on the next edge; the run is abandoned and no partial result is kept.

## Timing
- All outputs are registered.
- Reset values: `procReset_L` 0, `startPC` 0, `busy` 0, `done` 0, `progIdx` 0, `passMask` 0, `timeoutMask` 0, `passCount` 0, `allPassed` 0, `failData` 0.
- `start` → `busy` = 1 and `procReset_L` = 0 one cycle later.
- Processor released after RESET_CYCLES cycles in PRST.
- End PC seen in cycle N → CHECK samples `dMemOut` at cycle N+SETTLE_CYCLES+1.
- Per-program overhead outside RUN: RESET_CYCLES + SETTLE_CYCLES + 2 cycles.
- Timeout occurs after 2^WDOG_W−1 RUN cycles.
- `start` while `busy` has no effect. `start` coinciding with `Reset`: `Reset` wins.

## Structure
- Package `prog_check_pkg` holds:
  - the FSM state enum `prog_check_state_t`;
  - the helper `IDX_W(n)` for the `progIdx` width.
- Sub-module `wdog_counter` (WDOG_W-wide):
  - inputs `clr` and `en`;
  - output `expired` (count == all-ones);
  - saturates at all-ones.

## Test plan
- NUM_PROGS = 1; a processor model steps PC by 4 from 0; endPC = 0x30; expected = 0xF; `dMemOut` = 0xF → `passMask` = 1, `passCount` = 1, `allPassed` = 1, `done` high.
- NUM_PROGS = 4, expected values 0xF/0x1/0x2/0x3, model returns 0xF/0x1/0x7/0x3 → `passMask` = 4'b1011, `passCount` = 3, `failData` = 0x7, `allPassed` = 0.
- WDOG_W = 4, PC stuck at 0, endPC = 0x30 → timeout after 15 RUN cycles, `timeoutMask`[0] = 1, `passMask`[0] = 0, sequence continues to slot 1.
- End PC and watchdog expiry in the same cycle → SETTLE is entered, `timeoutMask` bit stays 0.
- `Reset` asserted in RUN of slot 2 → next cycle all outputs at reset values and `procReset_L` = 0. A new `start` then restarts from slot 0 with cleared masks.
- SETTLE_CYCLES = 0 and RESET_CYCLES = 3 → `procReset_L` low exactly 3 cycles per slot, CHECK immediately after end PC. `start` pulsed mid-run is ignored.
